// File: rtl/muladd_pkg.sv
// Shared widths, signed bound constants and operand extension for the multiply-add unit.
package muladd_pkg;

  localparam int MAX_W     = 64;
  localparam int A_W_DEF   = 8;
  localparam int B_W_DEF   = 8;
  localparam int C_W_DEF   = 7;
  localparam int ACC_W_DEF = 20;

  // Exact product of an (a_w+1)-bit and a (b_w+1)-bit signed operand.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  // Two guard bits above the accumulator so result + p + c never wraps.
  function automatic int sum_width(input int acc_w);
    return acc_w + 2;
  endfunction

  function automatic logic [MAX_W-1:0] max_bound(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] min_bound(input int w);
    return ~max_bound(w);
  endfunction

  // Extend the low w bits of v to 64 bits, sign- or zero-filling the rest.
  function automatic logic [MAX_W-1:0] ext_op(input logic [MAX_W-1:0] v, input int w,
                                               input logic is_signed);
    logic [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    if (is_signed) return $signed(t) >>> (MAX_W - w);
    return t >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/muladd_sat.sv
// Range check of the wide sum against the accumulator width, with clamp or wrap.
module muladd_sat
  import muladd_pkg::*;
#(
  parameter int IN_W     = 22,
  parameter int OUT_W    = 20,
  parameter bit SATURATE = 1'b0
) (
  input  logic [IN_W-1:0]  s,
  output logic [OUT_W-1:0] res,
  output logic             of
);

  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(max_bound(OUT_W));
  localparam logic [OUT_W-1:0] MIN_V = OUT_W'(min_bound(OUT_W));

  logic [IN_W-OUT_W:0] top_bits;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    top_bits = s[IN_W-1:OUT_W-1];
    // In range only when the discarded bits all replicate the new sign bit.
    of       = !((&top_bits) || !(|top_bits));
    res      = s[OUT_W-1:0];
    if (SATURATE && of) res = s[IN_W-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/muladd_seq_param.sv
// Two-stage multiply-add / multiply-accumulate with clock enable, sync clear and sticky overflow.
module muladd_seq_param
  import muladd_pkg::*;
#(
  parameter int A_W      = A_W_DEF,
  parameter int B_W      = B_W_DEF,
  parameter int C_W      = C_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             acc_mode,
  output logic             out_valid,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int PROD_W = prod_width(A_W, B_W);
  localparam int SUM_W  = sum_width(ACC_W);

  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [C_W-1:0] c_q, c_d;
  logic           a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d;
  logic           acc_mode_q, acc_mode_d, v1_q, v1_d;

  logic             out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [ACC_W-1:0] result_q, result_d, sat_res;
  logic             sat_of;

  logic signed [PROD_W-1:0] a_p, b_p, prod;
  logic [SUM_W-1:0]         acc_ext, sum;

  // Stage 1: operand capture; clear only kills the valid, so new operands are ignored.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    a_sgn_d    = a_sgn_q;
    b_sgn_d    = b_sgn_q;
    acc_mode_d = acc_mode_q;
    v1_d       = v1_q;
    if (clr) begin
      v1_d = 1'b0;
    end else if (en) begin
      a_d        = a;
      b_d        = b;
      c_d        = c;
      a_sgn_d    = a_signed;
      b_sgn_d    = b_signed;
      acc_mode_d = acc_mode;
      v1_d       = in_valid;
    end
  end

  // Stage 2 datapath: accumulate reads result_q directly, so back-to-back chains need no bypass.
  always_comb begin
    a_p     = PROD_W'(ext_op(MAX_W'(a_q), A_W, a_sgn_q));
    b_p     = PROD_W'(ext_op(MAX_W'(b_q), B_W, b_sgn_q));
    prod    = a_p * b_p;
    acc_ext = acc_mode_q ? {{2{result_q[ACC_W-1]}}, result_q} : '0;
    sum     = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod} + SUM_W'(c_q) + acc_ext;
  end

  muladd_sat #(
    .IN_W    (SUM_W),
    .OUT_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_sat (
    .s  (sum),
    .res(sat_res),
    .of (sat_of)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    if (clr) begin
      out_valid_d = 1'b0;
      result_d    = '0;
      ovf_d       = 1'b0;
    end else if (en) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        result_d = sat_res;
        ovf_d    = ovf_q | sat_of;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      a_sgn_q     <= 1'b0;
      b_sgn_q     <= 1'b0;
      acc_mode_q  <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      a_sgn_q     <= a_sgn_d;
      b_sgn_q     <= b_sgn_d;
      acc_mode_q  <= acc_mode_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule
